// File: rtl/irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl
//
// This is the request-collection stage in front of the 8-to-3 priority encoder.
// It detects rising edges on the request lines and latches them as sticky
// pending bits. It then offers the highest eligible line (pending and enabled)
// to a consumer over a valid/ack handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_in     [N-1:0]    level request lines, already synchronous to clk
//   mask_in    [N-1:0]    per-line enable, 1 = eligible for selection
//   irq_ack    consumer acknowledge of the current offer
//   irq_valid  an id is on offer
//   irq_id     [ID_W-1:0] offered line number (bit 7 highest priority)
//   pending    [N-1:0]    registered pending bits, before masking
//   overrun    sticky flag: a rising edge hit a line that was already pending
//
// Every output comes from a register, so no path runs combinationally from
// an input to an output. ID_W must satisfy 2**ID_W == N (the pair is 8/3).
// -----------------------------------------------------------------------------
module irq_pending_ctrl #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_in,
  input  logic [N-1:0]    mask_in,
  input  logic            irq_ack,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  output logic [N-1:0]    pending,
  output logic            overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    req_q;
  logic [N-1:0]    rise;
  logic [N-1:0]    clr;
  logic [N-1:0]    eligible;
  logic [N-1:0]    pending_nxt;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] id_nxt;
  logic            valid_nxt;

  // A line that stays high produces one request only. It has to fall and
  // rise again before it can request a second time.
  assign rise = req_in & ~req_q;

  // The offered line is cleared only when it is acknowledged during OFFER.
  // An ack that arrives in any other state is ignored.
  always_comb begin
    // NOTE: assign every always_comb output a default first, so no path
    // can leave it unassigned and infer a latch.
    clr = '0;
    if (state == OFFER && irq_ack) clr[irq_id] = 1'b1;
  end

  // If a line is set and cleared on the same edge, the set wins. A fresh
  // edge that arrives together with the ack therefore keeps the line pending.
  assign pending_nxt = (pending & ~clr) | rise;
  assign eligible    = pending & mask_in;

  // Priority select: the loop runs upward, so the highest set bit is the
  // last one to write sel and the highest index wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  // Next-state and next-output logic. In OFFER, irq_id is deliberately left
  // unchanged: the offer stands until it is acked, even if a higher line
  // arrives or the mask changes.
  always_comb begin
    state_nxt = state;
    valid_nxt = irq_valid;
    id_nxt    = irq_id;
    unique case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (|eligible) begin
          id_nxt    = sel;
          valid_nxt = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        valid_nxt = 1'b1;
        if (irq_ack) begin
          valid_nxt = 1'b0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        // Holding valid low for one cycle stops the consumer from
        // acknowledging the same offer twice.
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments,
  // so every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      // Load req_q with the live request level. Lines that are already
      // high when reset is released do not appear as new edges.
      req_q     <= req_in;
      pending   <= '0;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_q     <= req_in;
      pending   <= pending_nxt;
      irq_valid <= valid_nxt;
      irq_id    <= id_nxt;
      // A bit cleared by this ack is free again, so an edge on it counts
      // as a new request and not as an overrun.
      if (|(rise & pending & ~clr)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_ctrl
//
// Directed scenarios, followed by a randomized phase. A behavioural reference
// model, described in terms of offers and pending sets, checks every clock.
// Some directed steps also compare against explicit expected constants.
// -----------------------------------------------------------------------------
module tb_irq_pending_ctrl;

  localparam int N    = 8;
  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_in;
  logic [N-1:0]    mask_in;
  logic            irq_ack;
  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic [N-1:0]    pending;
  logic            overrun;

  int n_cmp = 0;
  int n_err = 0;

  irq_pending_ctrl #(.N(N), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask_in   (mask_in),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_pend;       // set of pending lines, held as an integer bitmask
  int m_last_req;   // request levels seen at the previous edge
  bit m_offering;   // an offer is outstanding
  bit m_cooldown;   // valid-low cycle after an ack
  int m_id;         // line currently or most recently offered
  bit m_overrun;

  function automatic int highest(input int set);
    for (int i = N - 1; i >= 0; i--) begin
      if ((set >> i) & 1) return i;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge, using the inputs as they were at
  // that edge.
  task automatic model_edge();
    int req, fresh, taken, elig;
    req = int'(req_in);
    if (rst) begin
      m_pend = 0; m_offering = 0; m_cooldown = 0; m_id = 0; m_overrun = 0;
      m_last_req = req;
      return;
    end
    fresh = req & ~m_last_req & 'hFF;
    taken = (m_offering && irq_ack) ? (1 << m_id) : 0;
    if ((fresh & m_pend & ~taken) != 0) m_overrun = 1;
    // The next offer decision uses the pending set as it was before this edge.
    elig = m_pend & int'(mask_in);
    m_pend = (m_pend & ~taken) | fresh;
    if (m_offering) begin
      if (irq_ack) begin m_offering = 0; m_cooldown = 1; end
    end else if (m_cooldown) begin
      m_cooldown = 0;
    end else if (elig != 0) begin
      m_id = highest(elig);
      m_offering = 1;
    end
    m_last_req = req;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run one clock edge, update the model, then compare every output
  // against the model 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_pending", int'(pending), m_pend);
    check("model_valid", int'(irq_valid), int'(m_offering));
    check("model_id", int'(irq_id), m_id);
    check("model_overrun", int'(overrun), int'(m_overrun));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; req_in = 8'hFF; mask_in = 8'hFF; irq_ack = 1'b0;
    m_pend = 0; m_last_req = 0; m_offering = 0; m_cooldown = 0; m_id = 0; m_overrun = 0;

    // Reset while every line is held high, then release: no requests appear.
    ticks(2);
    check("rst_pending", int'(pending), 0);
    check("rst_valid", int'(irq_valid), 0);
    check("rst_id", int'(irq_id), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_high_valid", int'(irq_valid), 0);
    end
    check("held_high_pending", int'(pending), 0);
    check("held_high_overrun", int'(overrun), 0);

    // Pulse 0x12: id 4 is offered first, then id 1.
    req_in = 8'h00; tick();
    req_in = 8'h12; tick();
    check("p12_pending", int'(pending), 'h12);
    check("p12_valid_k", int'(irq_valid), 0);
    req_in = 8'h00; tick();
    check("p12_valid", int'(irq_valid), 1);
    check("p12_id4", int'(irq_id), 4);
    irq_ack = 1'b1; tick();
    check("p12_gap_valid", int'(irq_valid), 0);
    check("p12_after_ack", int'(pending), 'h02);
    irq_ack = 1'b0; tick();
    check("p12_idle_valid", int'(irq_valid), 0);
    tick();
    check("p12_id1", int'(irq_id), 1);
    check("p12_valid2", int'(irq_valid), 1);
    irq_ack = 1'b1; tick();
    check("p12_empty", int'(pending), 0);
    check("p12_done_valid", int'(irq_valid), 0);
    irq_ack = 1'b0; ticks(2);

    // A masked line stays pending; it is offered once it is unmasked.
    mask_in = 8'h0F;
    req_in = 8'h84; tick();
    req_in = 8'h00; tick();
    check("mask_id2", int'(irq_id), 2);
    irq_ack = 1'b1; tick();
    check("mask_pend80", int'(pending), 'h80);
    irq_ack = 1'b0; ticks(2);
    check("mask_blocked", int'(irq_valid), 0);
    mask_in = 8'hFF; tick();
    check("unmask_valid", int'(irq_valid), 1);
    check("unmask_id7", int'(irq_id), 7);
    irq_ack = 1'b1; tick();
    irq_ack = 1'b0; ticks(2);

    // A higher line that arrives mid-offer does not displace the offer.
    req_in = 8'h08; tick();
    req_in = 8'h00; tick();
    check("hold_id3", int'(irq_id), 3);
    req_in = 8'h40; tick();
    check("hold_pend48", int'(pending), 'h48);
    req_in = 8'h00; ticks(3);
    check("hold_still3", int'(irq_id), 3);
    irq_ack = 1'b1; tick();
    irq_ack = 1'b0; ticks(2);
    check("hold_next6", int'(irq_id), 6);
    check("hold_next_valid", int'(irq_valid), 1);
    irq_ack = 1'b1; tick();
    irq_ack = 1'b0; ticks(2);

    // A new edge together with the ack: the set wins and there is no overrun.
    req_in = 8'h20; tick();
    req_in = 8'h00; tick();
    check("sim_id5", int'(irq_id), 5);
    req_in = 8'h20; irq_ack = 1'b1; tick();
    check("sim_pend", int'(pending), 'h20);
    check("sim_no_ovr", int'(overrun), 0);
    req_in = 8'h00; irq_ack = 1'b0; ticks(2);
    check("sim_reoffer", int'(irq_id), 5);
    check("sim_reoffer_v", int'(irq_valid), 1);
    req_in = 8'h20; tick();
    check("ovr_set", int'(overrun), 1);
    req_in = 8'h00; irq_ack = 1'b1; tick();
    irq_ack = 1'b0; ticks(2);
    check("ovr_sticky", int'(overrun), 1);

    // Reset during an offer drops it. An ack in IDLE is ignored.
    req_in = 8'h01; tick();
    req_in = 8'h00; tick();
    check("rstoff_id0", int'(irq_valid), 1);
    rst = 1'b1; tick();
    check("rstoff_valid", int'(irq_valid), 0);
    check("rstoff_pend", int'(pending), 0);
    check("rstoff_ovr", int'(overrun), 0);
    rst = 1'b0; irq_ack = 1'b1; ticks(2);
    irq_ack = 1'b0; tick();
    check("idle_ack_valid", int'(irq_valid), 0);
    req_in = 8'h04; irq_ack = 1'b1; tick();
    check("idle_ack_pend", int'(pending), 'h04);
    req_in = 8'h00; tick();
    check("idle_ack_offer", int'(irq_valid), 1);
    check("idle_ack_id", int'(irq_id), 2);
    irq_ack = 1'b0; ticks(3);

    // Random phase, checked against the reference model on every clock.
    for (int c = 0; c < 3000; c++) begin
      req_in  = req_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) mask_in = 8'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; irq_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
